controle_ula: RTL and testbench

Multi-cycle execution controller on the initiator side of the ALU interface (`select`, `X`, `Y` → `resultado`, `N`, `Z`). It accepts 16-bit register-to-register instructions over a valid/ready handshake and reads two operands from an internal 8×16 register file. It drives the ALU with them, writes the result back, and optionally latches the N/Z flags. It sits between instruction fetch and the ALU in the processor datapath.

---
 rtl/controle_ula_pkg.sv | 50 +++++
 rtl/controle_ula_if.sv | 19 +
 rtl/controle_ula_banco_reg.sv | 36 +++
 rtl/controle_ula.sv | 118 +++++++++++
 tb/tb_controle_ula.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/controle_ula_pkg.sv
// Shared types for the ALU execution controller.
// FSM states, ALU opcodes, instruction field positions and decode.
package controle_ula_pkg;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    EXECUTA = 2'd1,
    CONCLUI = 2'd2
  } estado_t;

  localparam logic [2:0] OP_SOMA  = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_NOT   = 3'b100;
  localparam logic [2:0] OP_SHR   = 3'b101;
  localparam logic [2:0] OP_SHL   = 3'b110;
  localparam logic [2:0] OP_PASSA = 3'b111;

  localparam int SEL_HI = 15;
  localparam int SEL_LO = 13;
  localparam int RD_HI  = 12;
  localparam int RD_LO  = 10;
  localparam int RX_HI  = 9;
  localparam int RX_LO  = 7;
  localparam int RY_HI  = 6;
  localparam int RY_LO  = 4;
  localparam int GRAVA  = 3;

  typedef struct packed {
    logic [2:0] sel;
    logic [2:0] rd;
    logic [2:0] rx;
    logic [2:0] ry;
    logic       grava;
  } instr_t;

  function automatic instr_t decodifica(
    input logic [15:0] w
  );
    instr_t d;
    d.sel   = w[SEL_HI:SEL_LO];
    d.rd    = w[RD_HI:RD_LO];
    d.rx    = w[RX_HI:RX_LO];
    d.ry    = w[RY_HI:RY_LO];
    d.grava = w[GRAVA];
    return d;
  endfunction

endpackage

// File: rtl/controle_ula_if.sv
// Instruction valid/ready handshake between fetch and the controller.
// master = producer (fetch), slave = controller.
interface controle_ula_if;
  logic [15:0] instr;
  logic        instr_valido;
  logic        instr_pronto;

  modport master (
    output instr,
    output instr_valido,
    input  instr_pronto
  );

  modport slave (
    input  instr,
    input  instr_valido,
    output instr_pronto
  );
endinterface

// File: rtl/controle_ula_banco_reg.sv
// 8x16 register file: one sync write port, three async read ports.
// Ports: clock/reset, we/wa/wd write, ra_*/rd_* reads, sync clear.
module banco_reg #(
  parameter int NREG = 8,
  parameter int LARG = 16,
  parameter int AW   = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [LARG-1:0] wd,
  input  logic [AW-1:0]   ra_x,
  input  logic [AW-1:0]   ra_y,
  input  logic [AW-1:0]   ra_d,
  output logic [LARG-1:0] rd_x,
  output logic [LARG-1:0] rd_y,
  output logic [LARG-1:0] rd_d
);

  logic [LARG-1:0] mem [NREG];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++)
        mem[i] <= '0;
    end else if (we) begin
      mem[wa] <= wd;
    end
  end

  assign rd_x = mem[ra_x];
  assign rd_y = mem[ra_y];
  assign rd_d = mem[ra_d];

endmodule

// File: rtl/controle_ula.sv
// Multi-cycle ALU execution controller: accept, execute, complete.
// Ports: bus handshake, esc_* write, le_* debug read, ula_* ALU, results.
module controle_ula
  import controle_ula_pkg::*;
#(
  parameter int NREG = 8,
  parameter int LARG = 16
) (
  input  logic            clock,
  input  logic            reset,
  controle_ula_if.slave   bus,
  input  logic            esc_en,
  input  logic [2:0]      esc_end,
  input  logic [LARG-1:0] esc_dado,
  input  logic [2:0]      le_end,
  output logic [LARG-1:0] le_dado,
  output logic [2:0]      ula_select,
  output logic [LARG-1:0] ula_x,
  output logic [LARG-1:0] ula_y,
  input  logic [LARG-1:0] ula_resultado,
  input  logic            ula_n,
  input  logic            ula_z,
  output logic [LARG-1:0] resultado,
  output logic            flag_n,
  output logic            flag_z,
  output logic            concluido
);

  estado_t         estado;
  estado_t         prox;
  instr_t          ir;
  logic            aceita;
  logic            we;
  logic [2:0]      wa;
  logic [LARG-1:0] wd;
  logic [LARG-1:0] op_x;
  logic [LARG-1:0] op_y;

  banco_reg #(
    .NREG (NREG),
    .LARG (LARG),
    .AW   (3)
  ) u_banco (
    .clock (clock),
    .reset (reset),
    .we    (we),
    .wa    (wa),
    .wd    (wd),
    .ra_x  (ir.rx),
    .ra_y  (ir.ry),
    .ra_d  (le_end),
    .rd_x  (op_x),
    .rd_y  (op_y),
    .rd_d  (le_dado)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      estado    <= OCIOSO;
      ir        <= '0;
      resultado <= '0;
      flag_n    <= 1'b0;
      flag_z    <= 1'b0;
    end else begin
      estado <= prox;
      if (aceita)
        ir <= decodifica(bus.instr);
      if (estado == EXECUTA) begin
        resultado <= ula_resultado;
        if (ir.grava) begin
          flag_n <= ula_n;
          flag_z <= ula_z;
        end
      end
    end
  end

  // The write port is shared: external writes own it in OCIOSO,
  // writeback owns it in EXECUTA, so esc_en is simply dropped there.
  always_comb begin
    prox             = estado;
    aceita           = 1'b0;
    bus.instr_pronto = 1'b0;
    concluido        = 1'b0;
    ula_select       = OP_PASSA;
    ula_x            = '0;
    ula_y            = '0;
    we               = 1'b0;
    wa               = esc_end;
    wd               = esc_dado;
    unique case (estado)
      OCIOSO: begin
        bus.instr_pronto = !esc_en;
        if (esc_en) begin
          we = 1'b1;
        end else if (bus.instr_valido) begin
          aceita = 1'b1;
          prox   = EXECUTA;
        end
      end
      EXECUTA: begin
        ula_select = ir.sel;
        ula_x      = op_x;
        ula_y      = op_y;
        we         = 1'b1;
        wa         = ir.rd;
        wd         = ula_resultado;
        prox       = CONCLUI;
      end
      CONCLUI: begin
        concluido = 1'b1;
        prox      = OCIOSO;
      end
      default: prox = OCIOSO;
    endcase
  end

endmodule

// File: tb/tb_controle_ula.sv
// Randomized scoreboard bench for controle_ula with an ALU model.
// Driver pushes expected results; negedge monitor pops on concluido.
`timescale 1ns/100ps
module tb_controle_ula;
  import controle_ula_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        esc_en = 1'b0;
  logic [2:0]  esc_end = '0;
  logic [15:0] esc_dado = '0;
  logic [2:0]  le_end = '0;
  logic [15:0] le_dado;
  logic [2:0]  ula_select;
  logic [15:0] ula_x, ula_y, ula_resultado;
  logic        ula_n, ula_z;
  logic [15:0] resultado;
  logic        flag_n, flag_z, concluido;

  controle_ula_if bus ();

  controle_ula dut (
    .clock         (clock),
    .reset         (reset),
    .bus           (bus),
    .esc_en        (esc_en),
    .esc_end       (esc_end),
    .esc_dado      (esc_dado),
    .le_end        (le_end),
    .le_dado       (le_dado),
    .ula_select    (ula_select),
    .ula_x         (ula_x),
    .ula_y         (ula_y),
    .ula_resultado (ula_resultado),
    .ula_n         (ula_n),
    .ula_z         (ula_z),
    .resultado     (resultado),
    .flag_n        (flag_n),
    .flag_z        (flag_z),
    .concluido     (concluido)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  function automatic logic [15:0] alu_ref(
    input logic [2:0] s, input logic [15:0] x, input logic [15:0] y
  );
    case (s)
      OP_SOMA: return x + y;
      OP_SUB:  return x - y;
      OP_AND:  return x & y;
      OP_OR:   return x | y;
      OP_NOT:  return ~x;
      OP_SHR:  return x >> 1;
      OP_SHL:  return x << 1;
      default: return x;
    endcase
  endfunction

  // External ALU stand-in
  always_comb begin
    ula_resultado = alu_ref(ula_select, ula_x, ula_y);
    ula_n = ula_resultado[15];
    ula_z = (ula_resultado == 16'h0);
  end

  function automatic void check(
    input string nm, input logic [31:0] act, input logic [31:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endfunction

  typedef struct {
    logic [15:0] res;
    logic        n;
    logic        z;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   conc[$];

  logic [15:0] m [8];
  logic        mfn = 1'b0;
  logic        mfz = 1'b0;
  logic [15:0] mres = '0;
  int          last_acc = -100;

  always @(negedge clock) begin
    if (!reset && concluido === 1'b1) begin
      exp_t e;
      conc.push_back(cyc);
      if (q.size() == 0) begin
        check("concluido_unexpected", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("latency", cyc - e.cyc, 32'd2);
        check("resultado", resultado, e.res);
        check("flag_n", flag_n, e.n);
        check("flag_z", flag_z, e.z);
        check("pronto_in_conclui", bus.instr_pronto, 1'b0);
      end
    end
  end

  function automatic logic [15:0] mk(
    input logic [2:0] s, input logic [2:0] d,
    input logic [2:0] x, input logic [2:0] y, input logic g
  );
    return {s, d, x, y, g, 3'b000};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m[i] = '0;
    mfn = 0; mfz = 0; mres = '0;
    last_acc = -100;
  endtask

  // Called at negedge+1; returns at negedge+1 of the EXECUTA cycle
  task automatic issue(input logic [15:0] w, input bit hold);
    int n = 0;
    exp_t e;
    logic [15:0] xv, yv;
    bus.instr = w;
    bus.instr_valido = 1'b1;
    #1;
    while (bus.instr_pronto !== 1'b1 && n < 20) begin
      @(negedge clock); #1; n++;
    end
    if (n >= 20) begin
      check("accept_timeout", 32'd1, 32'd0);
      bus.instr_valido = 1'b0;
      return;
    end
    xv = m[w[9:7]];
    yv = m[w[6:4]];
    e.res = alu_ref(w[15:13], xv, yv);
    if (w[3]) begin
      mfn = e.res[15];
      mfz = (e.res == 16'h0);
    end
    e.n = mfn;
    e.z = mfz;
    e.cyc = cyc;
    m[w[12:10]] = e.res;
    mres = e.res;
    last_acc = cyc;
    q.push_back(e);
    @(negedge clock); #1;
    check("ula_select", ula_select, w[15:13]);
    check("ula_x", ula_x, xv);
    check("ula_y", ula_y, yv);
    check("pronto_in_executa", bus.instr_pronto, 1'b0);
    if (!hold) bus.instr_valido = 1'b0;
  endtask

  task automatic esc(input logic [2:0] a, input logic [15:0] d);
    esc_en = 1'b1; esc_end = a; esc_dado = d;
    if (!(cyc == last_acc + 1 || cyc == last_acc + 2))
      m[a] = d;
    @(negedge clock); #1;
    esc_en = 1'b0;
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [15:0] v);
    le_end = a;
    #0.2;
    v = le_dado;
  endtask

  task automatic chk_regs();
    logic [15:0] v;
    for (int i = 0; i < 8; i++) begin
      rd_reg(i[2:0], v);
      check($sformatf("reg%0d", i), v, m[i]);
    end
  endtask

  task automatic idle(input int k);
    repeat (k) begin @(negedge clock); #1; end
  endtask

  initial begin
    logic [15:0] v;
    int n0;
    bus.instr = '0;
    bus.instr_valido = 1'b0;
    model_reset();
    idle(3);
    reset = 1'b0;
    #0.5;
    check("rst_pronto", bus.instr_pronto, 1'b1);
    check("rst_concluido", concluido, 1'b0);
    check("rst_resultado", resultado, 16'h0);
    check("rst_flags", {flag_n, flag_z}, 2'b00);
    check("rst_select", ula_select, OP_PASSA);
    check("rst_xy", {ula_x, ula_y}, 32'h0);
    chk_regs();

    esc(3'd1, 16'h0005);
    esc(3'd2, 16'h0003);
    issue(mk(OP_SOMA, 3'd3, 3'd1, 3'd2, 1'b1), 0);
    idle(1);
    rd_reg(3'd3, v);
    check("soma_r3", v, 16'h0008);
    check("soma_nz", {flag_n, flag_z}, 2'b00);
    issue(mk(OP_SUB, 3'd4, 3'd2, 3'd1, 1'b1), 0);
    idle(1);
    rd_reg(3'd4, v);
    check("sub_r4", v, 16'hFFFE);
    check("sub_nz", {flag_n, flag_z}, 2'b10);
    issue(mk(OP_SUB, 3'd5, 3'd1, 3'd1, 1'b0), 0);
    idle(1);
    rd_reg(3'd5, v);
    check("sub0_r5", v, 16'h0000);
    check("sub0_keepflags", {flag_n, flag_z}, 2'b10);
    issue(mk(OP_SHL, 3'd1, 3'd1, 3'd0, 1'b0), 0);
    idle(1);
    rd_reg(3'd1, v);
    check("shl_hazard_r1", v, 16'h000A);

    // back-to-back with valid held high
    idle(1);
    n0 = conc.size();
    issue(mk(OP_OR, 3'd6, 3'd1, 3'd2, 1'b1), 1);
    issue(mk(OP_AND, 3'd7, 3'd6, 3'd4, 1'b1), 1);
    issue(mk(OP_NOT, 3'd0, 3'd7, 3'd0, 1'b1), 0);
    idle(3);
    check("hold_count", conc.size() - n0, 32'd3);
    if (conc.size() - n0 == 3) begin
      check("hold_gap1", conc[n0+1] - conc[n0], 32'd3);
      check("hold_gap2", conc[n0+2] - conc[n0+1], 32'd3);
    end

    // esc and valid together: write wins, accept afterwards
    bus.instr = mk(OP_PASSA, 3'd7, 3'd6, 3'd0, 1'b1);
    bus.instr_valido = 1'b1;
    esc_en = 1'b1; esc_end = 3'd6; esc_dado = 16'h00F0;
    #1;
    check("esc_blocks_pronto", bus.instr_pronto, 1'b0);
    m[6] = 16'h00F0;
    @(negedge clock); #1;
    esc_en = 1'b0;
    issue(mk(OP_PASSA, 3'd7, 3'd6, 3'd0, 1'b1), 0);
    esc(3'd5, 16'h1234);
    idle(1);
    rd_reg(3'd7, v);
    check("passa_r7", v, 16'h00F0);
    rd_reg(3'd5, v);
    check("esc_busy_ignored", v, 16'h0000);
    chk_regs();

    // reset mid-instruction
    issue(mk(OP_SOMA, 3'd2, 3'd1, 3'd6, 1'b1), 0);
    reset = 1'b1;
    void'(q.pop_back());
    model_reset();
    @(negedge clock); #1;
    reset = 1'b0;
    #0.5;
    check("abort_pronto", bus.instr_pronto, 1'b1);
    check("abort_resultado", resultado, 16'h0);
    check("abort_flags", {flag_n, flag_z}, 2'b00);
    chk_regs();

    // randomized traffic
    for (int i = 0; i < 8; i++) esc(i[2:0], 16'($urandom));
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 9) < 3) begin
        esc(3'($urandom), 16'($urandom));
      end else begin
        issue(16'($urandom), 0);
        if ($urandom_range(0, 3) == 0)
          esc(3'($urandom), 16'($urandom));
      end
    end
    idle(4);
    check("queue_empty", q.size(), 32'd0);
    check("final_resultado", resultado, mres);
    check("final_flags", {flag_n, flag_z}, {mfn, mfz});
    chk_regs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
